// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, fetch entry record and fetch FSM states.
package riscv_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush and occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic do_pop;
  assign do_pop = pop_i & (cnt_q != '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(do_pop);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem request issuer; buffers in-order responses for decode
// and drops responses made stale by a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [DATA_WIDTH-1:0]    dec_instr,
  output logic [ADDRESS_WIDTH-1:0] dec_pc,
  output logic [6:0]               dec_op,
  output logic [2:0]               dec_funct3,
  output logic                     dec_funct7
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, tag_head;
  logic [CW-1:0] stale_q, stale_d, tag_cnt, buf_cnt, outstanding, budget;
  logic [DW+AW-1:0] head;
  logic accept, rsp_live, pop;
  // every in-flight request is either tagged (live) or counted as stale
  assign outstanding = tag_cnt + stale_q;
  assign dec_valid   = buf_cnt != '0;
  assign pop         = dec_valid & dec_ready & !redirect;
  assign accept      = imem_req_valid & imem_req_ready;
  assign rsp_live    = imem_rsp_valid & (stale_q == '0) & !redirect;
  // a slot freed by this cycle's pop can be refilled, sustaining one instruction per cycle
  assign budget      = outstanding + buf_cnt - CW'(pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= BOOT;
    else state_q <= state_d;
  always_comb state_d = (state_q == BOOT) ? RUN : (stale_d != '0) ? FLUSH : RUN;
  always_comb begin
    imem_req_valid = (state_q != BOOT) & !redirect & (budget < CW'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
  end
  always_comb begin
    pc_d    = redirect ? (redirect_target & ~AW'(3)) : accept ? pc_q + AW'(4) : pc_q;
    stale_d = redirect ? outstanding - CW'(imem_rsp_valid)
            : (imem_rsp_valid && stale_q != '0) ? stale_q - CW'(1) : stale_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stale_q <= '0;
    end else begin
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end
  fetch_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_tags (
    .clk(clk), .rst(rst), .push_i(accept), .pop_i(rsp_live), .flush_i(redirect),
    .data_i(pc_q), .data_o(tag_head), .count_o(tag_cnt)
  );
  fetch_fifo #(.WIDTH(DW+AW), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .push_i(rsp_live), .pop_i(pop), .flush_i(redirect),
    .data_i({imem_rsp_data, tag_head}), .data_o(head), .count_o(buf_cnt)
  );
  always_comb begin
    dec_instr  = dec_valid ? head[AW+:DW] : '0;
    dec_pc     = dec_valid ? head[AW-1:0] : '0;
    dec_op     = dec_instr[6:0];
    dec_funct3 = dec_instr[14:12];
    dec_funct7 = dec_instr[30];
  end
endmodule
